// File: rtl/cdm_pkg.sv
// -----------------------------------------------------------------------------
// cdm_pkg
// Shared definitions for the carry-disregard sequential multiplier:
//   OP_W / PROD_W / CNT_W : operand, product and bit-counter widths
//   state_e               : multiplier FSM state encoding
//   low_mask(k)           : 16-bit mask with the low k bits set
// -----------------------------------------------------------------------------
package cdm_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Computed one bit wider so that k == PROD_W still yields all ones.
    function automatic logic [PROD_W-1:0] low_mask(input int unsigned k);
        logic [PROD_W:0] one_hot;
        one_hot = (PROD_W+1)'(1) << k;
        return PROD_W'(one_hot - (PROD_W+1)'(1));
    endfunction

endpackage : cdm_pkg

// File: rtl/cdm_seq_mult8_if.sv
// -----------------------------------------------------------------------------
// cdm_seq_mult8_if
// Operand and result handshakes of the sequential multiplier.
//   in_valid / in_ready / a / b         : operand channel (producer -> block)
//   out_valid / out_ready / product     : result channel  (block -> consumer)
// Modports:
//   master : the environment driving operands and consuming products
//   slave  : the multiplier itself
// -----------------------------------------------------------------------------
interface cdm_seq_mult8_if;
    import cdm_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );

endinterface : cdm_seq_mult8_if

// File: rtl/cla_sixteen.sv
// -----------------------------------------------------------------------------
// cla_sixteen
// 16-bit two-level carry-lookahead adder: four 4-bit lookahead groups whose
// group generate/propagate terms feed a second lookahead unit.
//   a, b : addends
//   cin  : carry in
//   s    : sum
//   cout : carry out of bit 15
// -----------------------------------------------------------------------------
module cla_sixteen (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);

    // Carries into bits 0..3 of a 4-wide lookahead group, all in parallel.
    function automatic logic [3:0] carries4(input logic [3:0] p,
                                            input logic [3:0] g,
                                            input logic       c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    function automatic logic group_gen(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [15:0] p;
    logic [15:0] g;
    logic [3:0]  grp_p;
    logic [3:0]  grp_g;
    logic [3:0]  grp_c;

    assign p = a ^ b;
    assign g = a & b;

    for (genvar n = 0; n < 4; n++) begin : g_group
        logic [3:0] c_bit;
        assign grp_p[n]      = &p[4*n +: 4];
        assign grp_g[n]      = group_gen(p[4*n +: 4], g[4*n +: 4]);
        assign c_bit         = carries4(p[4*n +: 4], g[4*n +: 4], grp_c[n]);
        assign s[4*n +: 4]   = p[4*n +: 4] ^ c_bit;
    end

    // Second level: carries into each group from the group G/P terms.
    assign grp_c = carries4(grp_p, grp_g, cin);
    assign cout  = group_gen(grp_p, grp_g) | ((&grp_p) & cin);

endmodule : cla_sixteen

// File: rtl/cdm_seq_mult8.sv
// -----------------------------------------------------------------------------
// cdm_seq_mult8
// Sequential 8x8 unsigned shift-and-add multiplier. One partial product is
// accumulated per cycle (8 cycles). The low APPROX_BITS accumulator columns are
// combined by OR (carries dropped); the upper columns go through cla_sixteen.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : operand/result handshakes (slave side), see cdm_seq_mult8_if
// Parameter:
//   APPROX_BITS : 0..8, number of OR-combined low columns (0 = exact product)
// -----------------------------------------------------------------------------
module cdm_seq_mult8
    import cdm_pkg::*;
#(
    parameter int unsigned APPROX_BITS = 0
) (
    input  logic             clk,
    input  logic             rst,
    cdm_seq_mult8_if.slave   bus
);

    localparam logic [PROD_W-1:0] LOW_M = low_mask(APPROX_BITS);

    state_e            state_q, state_d;
    logic [PROD_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [OP_W-1:0]   a_q,     a_d;
    logic [OP_W-1:0]   b_q,     b_d;

    logic [PROD_W-1:0] pp;
    logic [PROD_W-1:0] cla_s;
    logic              cla_cout;
    logic [PROD_W-1:0] acc_sum;

    // Partial product for the current multiplier bit.
    always_comb begin
        pp = b_q[cnt_q] ? (PROD_W'(a_q) << cnt_q) : '0;
    end

    // Low columns are forced to zero on both addends, so no carry can enter
    // column APPROX_BITS from below.
    cla_sixteen u_cla (
        .a    (acc_q & ~LOW_M),
        .b    (pp & ~LOW_M),
        .cin  (1'b0),
        .s    (cla_s),
        .cout (cla_cout)
    );

    always_comb begin
        acc_sum = (cla_s & ~LOW_M) | ((acc_q | pp) & LOW_M);
    end

    // The approximate sum never exceeds the exact product (<= 0xFE01), so the
    // adder carry-out must stay low while accumulating.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst) (state_q == RUN) |-> !cla_cout
    );

    // State register.
    // NOTE: every flop, including the operand and accumulator registers, is
    // cleared by reset so an aborted operation leaves no residue behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // flops sample pre-edge values regardless of statement order.
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: hold-value defaults first, so no path through the case
        // leaves a signal unassigned and infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid is the handshake.
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(OP_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state only.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.product   = (state_q == DONE) ? acc_q : '0;
    end

endmodule : cdm_seq_mult8

// File: tb/tb_cdm_seq_mult8.sv
// -----------------------------------------------------------------------------
// tb_cdm_seq_mult8
// Drives an exact (APPROX_BITS=0) and an approximate (APPROX_BITS=4) instance
// with identical stimulus and checks both against arithmetic expectations.
// -----------------------------------------------------------------------------
module tb_cdm_seq_mult8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cdm_seq_mult8_if if0 ();
    cdm_seq_mult8_if if4 ();

    cdm_seq_mult8 #(.APPROX_BITS(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    cdm_seq_mult8 #(.APPROX_BITS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp0;
        logic [15:0] exp4;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: sum of shifted partial products, low k columns OR-ed.
    function automatic logic [15:0] approx_mult(input logic [7:0] a, input logic [7:0] b,
                                                input int k);
        int unsigned acc = 0;
        int unsigned m   = (1 << k) - 1;
        for (int i = 0; i < 8; i++) begin
            int unsigned pp = b[i] ? (int'(a) << i) : 0;
            acc = (((acc & ~m) + (pp & ~m)) & ~m) | ((acc | pp) & m);
        end
        return 16'(acc);
    endfunction

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic ordy);
        if0.in_valid = v;  if4.in_valid = v;
        if0.a = a;         if4.a = a;
        if0.b = b;         if4.b = b;
        if0.out_ready = ordy; if4.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for out_valid; returns edges elapsed.
    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!if0.out_valid && cyc < 20);
    endtask

    task automatic run_txn(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp0, input logic [15:0] exp4);
        int cyc;
        check({name, " in_ready idle"}, 32'(if0.in_ready), 32'd1);
        drive(1'b1, a, b, 1'b0);
        tick();
        drive(1'b0, ~a, ~b, 1'b0);
        wait_out(cyc);
        check({name, " latency"}, 32'(cyc), 32'd8);
        check({name, " out_valid4"}, 32'(if4.out_valid), 32'd1);
        check({name, " product0"}, 32'(if0.product), 32'(exp0));
        check({name, " product4"}, 32'(if4.product), 32'(exp4));
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check({name, " out_valid after hs"}, 32'(if0.out_valid), 32'd0);
        check({name, " in_ready after hs"}, 32'(if4.in_ready), 32'd1);
    endtask

    initial begin
        int cyc;
        logic [15:0] held;
        logic [7:0] ra, rb;

        vecs[0] = '{8'h0D, 8'h0B, 16'h008F, 16'h007F};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 16'hFDDF};
        vecs[2] = '{8'h00, 8'hA5, 16'h0000, 16'h0000};
        vecs[3] = '{8'h0F, 8'h03, 16'h002D, 16'h001F};
        vecs[4] = '{8'h10, 8'h10, 16'h0100, 16'h0100};
        vecs[5] = '{8'h02, 8'h03, 16'h0006, 16'h0006};
        vecs[6] = '{8'hA5, 8'h00, 16'h0000, 16'h0000};

        // Reset state.
        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        #12;
        check("rst product", 32'(if0.product), 32'd0);
        check("rst out_valid", 32'(if0.out_valid), 32'd0);
        check("rst in_ready", 32'(if0.in_ready), 32'd1);
        rst = 1'b0;
        tick();
        check("post-rst in_ready", 32'(if4.in_ready), 32'd1);

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp0, vecs[i].exp4);
        end

        // Random vectors against the model.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_txn($sformatf("rand%0d", i), ra, rb, 16'(ra * rb), approx_mult(ra, rb, 4));
        end

        // Backpressure: result held, new operands ignored.
        drive(1'b1, 8'h0D, 8'h0B, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        wait_out(cyc);
        check("bp latency", 32'(cyc), 32'd8);
        held = if0.product;
        check("bp product", 32'(held), 32'h008F);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h30 + i), 8'h77, 1'b0);
            tick();
            check($sformatf("bp%0d out_valid", i), 32'(if0.out_valid), 32'd1);
            check($sformatf("bp%0d product", i), 32'(if0.product), 32'(held));
            check($sformatf("bp%0d product4", i), 32'(if4.product), 32'h007F);
            check($sformatf("bp%0d in_ready", i), 32'(if0.in_ready), 32'd0);
        end
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check("bp release in_ready", 32'(if0.in_ready), 32'd1);
        check("bp release out_valid", 32'(if0.out_valid), 32'd0);
        tick();
        check("bp no capture in_ready", 32'(if0.in_ready), 32'd1);

        // Reset mid-RUN.
        drive(1'b1, 8'h12, 8'h34, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("midrst out_valid", 32'(if0.out_valid), 32'd0);
        check("midrst product", 32'(if0.product), 32'd0);
        check("midrst in_ready", 32'(if0.in_ready), 32'd1);
        #3;
        rst = 1'b0;
        tick();
        run_txn("after rst", 8'h02, 8'h03, 16'h0006, 16'h0006);

        // Back-to-back with in_valid and out_ready held high.
        drive(1'b1, 8'h0D, 8'h0B, 1'b1);
        tick();
        drive(1'b1, 8'h10, 8'h10, 1'b1);
        wait_out(cyc);
        check("b2b first latency", 32'(cyc), 32'd8);
        check("b2b first product0", 32'(if0.product), 32'h008F);
        check("b2b first product4", 32'(if4.product), 32'h007F);
        check("b2b first in_ready", 32'(if0.in_ready), 32'd0);
        tick();
        check("b2b hs out_valid", 32'(if0.out_valid), 32'd0);
        check("b2b hs in_ready", 32'(if0.in_ready), 32'd1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        check("b2b second accepted", 32'(if0.in_ready), 32'd0);
        wait_out(cyc);
        check("b2b second latency", 32'(cyc), 32'd8);
        check("b2b second product0", 32'(if0.product), 32'h0100);
        check("b2b second product4", 32'(if4.product), 32'h0100);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check("b2b end in_ready", 32'(if0.in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_cdm_seq_mult8
